// File: rtl/frame_transition_ctrl.sv
// Dual frame-buffer sequencer: load back buffer, crossfade one step per vsync, swap roles.
// Latency: fb_* registered one cycle after each transfer; backpressure: pix_ready high only in LOAD, stalls unbounded.
module frame_transition_ctrl #(
    parameter int PIXELS = 76800,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        fade_step,
    input  logic              vsync,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_write_addr,
    output logic [DATA_W-1:0] fb_write_data,
    output logic              fb_buffer_select,
    output logic              fb_display_mode,
    output logic [7:0]        fb_blend_factor,
    output logic              front_buffer,
    output logic              busy,
    output logic              swap_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_VSYNC,
        S_FADE,
        S_SWAP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t            r_state, w_state_nxt;
    logic              r_front, w_front_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_bsel, w_bsel_nxt;
    logic              r_mode, w_mode_nxt;
    logic [7:0]        r_blend, w_blend_nxt;
    logic              r_swap, w_swap_nxt;
    logic [ADDR_W-1:0] r_count, w_count_nxt;
    logic [7:0]        r_step, w_step_nxt;

    logic              w_xfer;
    logic [8:0]        w_sum;
    logic [7:0]        w_up, w_down, w_stepped, w_start, w_target;

    assign pix_ready = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign w_xfer    = pix_valid & pix_ready;

    // Fade direction follows the front buffer: towards 255 when A is shown, towards 0 when B is.
    assign w_start   = r_front ? 8'hFF : 8'h00;
    assign w_target  = ~w_start;
    assign w_sum     = {1'b0, r_blend} + {1'b0, r_step};
    assign w_up      = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_down    = (r_blend < r_step) ? 8'h00 : (r_blend - r_step);
    assign w_stepped = r_front ? w_down : w_up;

    always_comb begin
        w_state_nxt = r_state;
        w_front_nxt = r_front;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_bsel_nxt  = r_bsel;
        w_mode_nxt  = r_mode;
        w_blend_nxt = r_blend;
        w_swap_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_step_nxt  = r_step;
        case (r_state)
            S_IDLE: begin
                w_bsel_nxt = r_front;
                w_mode_nxt = 1'b0;
                if (load_start) begin
                    w_step_nxt  = (fade_step == 8'd0) ? 8'hFF : fade_step;
                    w_count_nxt = '0;
                    w_blend_nxt = w_start;
                    w_bsel_nxt  = ~r_front;
                    w_mode_nxt  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_count;
                    w_wdata_nxt = pix_data;
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == LAST_ADDR) begin
                        w_state_nxt = S_WAIT_VSYNC;
                    end
                end
            end
            S_WAIT_VSYNC: begin
                if (vsync) begin
                    w_blend_nxt = w_stepped;
                    w_state_nxt = S_FADE;
                end
            end
            S_FADE: begin
                // Reaching TARGET takes one vsync; the next one swaps, so a full frame shows at TARGET.
                if (vsync) begin
                    if (r_blend == w_target) begin
                        w_state_nxt = S_SWAP;
                    end else begin
                        w_blend_nxt = w_stepped;
                    end
                end
            end
            S_SWAP: begin
                w_front_nxt = ~r_front;
                w_bsel_nxt  = ~r_front;
                w_mode_nxt  = 1'b0;
                w_swap_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_front <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_bsel  <= 1'b0;
            r_mode  <= 1'b0;
            r_blend <= 8'd0;
            r_swap  <= 1'b0;
            r_count <= '0;
            r_step  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_front <= w_front_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_bsel  <= w_bsel_nxt;
            r_mode  <= w_mode_nxt;
            r_blend <= w_blend_nxt;
            r_swap  <= w_swap_nxt;
            r_count <= w_count_nxt;
            r_step  <= w_step_nxt;
        end
    end

    assign fb_we            = r_we;
    assign fb_write_addr    = r_addr;
    assign fb_write_data    = r_wdata;
    assign fb_buffer_select = r_bsel;
    assign fb_display_mode  = r_mode;
    assign fb_blend_factor  = r_blend;
    assign front_buffer     = r_front;
    assign swap_done        = r_swap;

endmodule

// File: tb/tb_frame_transition_ctrl.sv
// Bench for frame_transition_ctrl with a 4-pixel frame: write scoreboard plus table-driven fade rows.
module tb_frame_transition_ctrl;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [7:0]  fade_step;
    logic        vsync;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        fb_we;
    logic [16:0] fb_write_addr;
    logic [15:0] fb_write_data;
    logic        fb_buffer_select;
    logic        fb_display_mode;
    logic [7:0]  fb_blend_factor;
    logic        front_buffer;
    logic        busy;
    logic        swap_done;

    frame_transition_ctrl #(.PIXELS(4), .ADDR_W(17), .DATA_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .fade_step        (fade_step),
        .vsync            (vsync),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_data         (pix_data),
        .fb_we            (fb_we),
        .fb_write_addr    (fb_write_addr),
        .fb_write_data    (fb_write_data),
        .fb_buffer_select (fb_buffer_select),
        .fb_display_mode  (fb_display_mode),
        .fb_blend_factor  (fb_blend_factor),
        .front_buffer     (front_buffer),
        .busy             (busy),
        .swap_done        (swap_done)
    );

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
        logic        bsel;
    } wr_t;

    typedef struct {
        logic       ls;
        logic       vs;
        logic [7:0] step;
        logic [7:0] exp_blend;
        logic       exp_swap;
        logic       exp_front;
        logic       exp_mode;
        logic       exp_bsel;
        logic       exp_busy;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  we_cnt = 0;
    wr_t sb[$];
    vec_t tbl[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Every registered write is popped against the entry pushed when its pixel was offered.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            we_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(fb_write_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(fb_write_addr), 32'(e.addr));
                chk("wr_data", 32'(fb_write_data), 32'(e.data));
                chk("wr_bsel", 32'(fb_buffer_select), 32'(e.bsel));
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    32'(fb_we), 0);
        chk({tag, "_addr"},  32'(fb_write_addr), 0);
        chk({tag, "_data"},  32'(fb_write_data), 0);
        chk({tag, "_bsel"},  32'(fb_buffer_select), 0);
        chk({tag, "_mode"},  32'(fb_display_mode), 0);
        chk({tag, "_blend"}, 32'(fb_blend_factor), 0);
        chk({tag, "_front"}, 32'(front_buffer), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_swap"},  32'(swap_done), 0);
        chk({tag, "_ready"}, 32'(pix_ready), 0);
    endtask

    // Loads pixels 0x1111..0x4444 with a one-cycle valid gap; the gap cycle also carries a
    // stray load_start and vsync that must be ignored.
    task automatic load4(input logic [7:0] stp, input logic fr);
        logic [7:0] st;
        int         sent;
        int         we0;
        wr_t        w;
        st   = fr ? 8'hFF : 8'h00;
        sent = 0;
        we0  = we_cnt;
        load_start = 1'b1;
        fade_step  = stp;
        tick;
        load_start = 1'b0;
        chk("load_busy",  32'(busy), 1);
        chk("load_ready", 32'(pix_ready), 1);
        chk("load_bsel",  32'(fb_buffer_select), 32'(!fr));
        chk("load_mode",  32'(fb_display_mode), 1);
        chk("load_blend", 32'(fb_blend_factor), 32'(st));
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                pix_valid  = 1'b0;
                load_start = 1'b1;
                vsync      = 1'b1;
                fade_step  = 8'h10;
            end else begin
                pix_valid = 1'b1;
                pix_data  = 16'(16'h1111 * (sent + 1));
                w.addr    = 17'(sent);
                w.data    = pix_data;
                w.bsel    = !fr;
                sb.push_back(w);
                sent++;
            end
            tick;
            pix_valid  = 1'b0;
            load_start = 1'b0;
            vsync      = 1'b0;
            if (c == 2) begin
                chk("gap_we",    32'(fb_we), 0);
                chk("gap_ready", 32'(pix_ready), 1);
                chk("gap_blend", 32'(fb_blend_factor), 32'(st));
            end
        end
        chk("ready_low", 32'(pix_ready), 0);
        chk("wait_busy", 32'(busy), 1);
        tick;
        chk("we_low",   32'(fb_we), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("we_count", 32'(we_cnt - we0), 4);
    endtask

    initial begin
        // ls vs step | blend swap front mode bsel busy   (front A, step 64, starting in WAIT_VSYNC)
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 8'd64,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h10, 8'd64,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'd128, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'd192, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 8'd255, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 8'd255, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        reset      = 1'b1;
        load_start = 1'b0;
        fade_step  = 8'h00;
        vsync      = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 16'h0000;

        repeat (4) tick;
        chk_reset("rst_held");
        reset = 1'b0;
        tick;
        chk_reset("rst_rel");

        load4(8'd64, 1'b0);

        for (int i = 0; i < 9; i++) begin
            load_start = tbl[i].ls;
            vsync      = tbl[i].vs;
            fade_step  = tbl[i].step;
            tick;
            load_start = 1'b0;
            vsync      = 1'b0;
            chk($sformatf("row%0d_blend", i), 32'(fb_blend_factor), 32'(tbl[i].exp_blend));
            chk($sformatf("row%0d_swap", i),  32'(swap_done),       32'(tbl[i].exp_swap));
            chk($sformatf("row%0d_front", i), 32'(front_buffer),    32'(tbl[i].exp_front));
            chk($sformatf("row%0d_mode", i),  32'(fb_display_mode), 32'(tbl[i].exp_mode));
            chk($sformatf("row%0d_bsel", i),  32'(fb_buffer_select), 32'(tbl[i].exp_bsel));
            chk($sformatf("row%0d_busy", i),  32'(busy),            32'(tbl[i].exp_busy));
            chk($sformatf("row%0d_ready", i), 32'(pix_ready),       0);
        end

        // Hard cut back to A while B is on display.
        load4(8'd0, 1'b1);
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        chk("cut_blend", 32'(fb_blend_factor), 0);
        chk("cut_busy",  32'(busy), 1);
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        chk("cut_noswap_yet", 32'(swap_done), 0);
        tick;
        chk("cut_swap",  32'(swap_done), 1);
        chk("cut_front", 32'(front_buffer), 0);
        chk("cut_bsel",  32'(fb_buffer_select), 0);
        chk("cut_mode",  32'(fb_display_mode), 0);
        chk("cut_busy0", 32'(busy), 0);
        tick;
        chk("cut_swap_pulse", 32'(swap_done), 0);

        // Reset in the middle of a fade.
        load4(8'd128, 1'b0);
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        chk("mid_blend", 32'(fb_blend_factor), 128);
        reset = 1'b1;
        tick;
        chk_reset("mid_rst");
        reset = 1'b0;
        tick;
        chk_reset("mid_rel");
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
